// File: rtl/wait_fare_meter_pkg.sv
// Shared fare definitions: meter state encoding and default minute constants
// so that the divider, the display and the meter agree on unit lengths.
package wait_fare_meter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRACE = 2'd1,
      ST_BILL  = 2'd2
   } meter_state_e;

   localparam int DEF_DAY_UNIT_MIN   = 10;
   localparam int DEF_NIGHT_UNIT_MIN = 5;
   localparam int DEF_GRACE_MIN      = 3;

endpackage

// File: rtl/wait_fare_meter_if.sv
// Status/strobe bundle between the divider/trip logic (master) and the
// wait fare meter (slave).
//
// Signalling: there is no valid/ready back-pressure on this bundle.
// tick_min, trip_start and fare_pulse are one-cycle strobes sampled on the
// rising clk edge; every cycle a strobe is high counts as one event.
// trip_active, waiting and night_mode are levels sampled every cycle.
// wait_min, wait_units, in_grace and sat are registered status levels.
interface wait_fare_meter_if #(
   parameter int CNT_W = 8
);
   logic             tick_min;
   logic             trip_start;
   logic             trip_active;
   logic             waiting;
   logic             night_mode;
   logic             fare_pulse;
   logic [CNT_W-1:0] wait_min;
   logic [CNT_W-1:0] wait_units;
   logic             in_grace;
   logic             sat;

   modport master (
      output tick_min, trip_start, trip_active, waiting, night_mode,
      input  fare_pulse, wait_min, wait_units, in_grace, sat
   );

   modport slave (
      input  tick_min, trip_start, trip_active, waiting, night_mode,
      output fare_pulse, wait_min, wait_units, in_grace, sat
   );
endinterface

// File: rtl/wait_fare_meter_sat_counter.sv
// Saturating up-counter with synchronous clear; sat is high while the
// count sits at all-ones.
module wait_fare_meter_sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clear,
   input  logic         inc,
   output logic [W-1:0] count,
   output logic         sat
);

   // Count up on inc, stop at all-ones, clear has priority.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (inc && (count != {W{1'b1}})) begin
         count <= count + W'(1);
      end
   end

   assign sat = &count;

endmodule

// File: rtl/wait_fare_meter.sv
// Waiting-time fare meter: qualifies minute strobes with trip/waiting
// status, burns a free grace period, then emits one fare pulse per
// completed billing unit (day or night length chosen at each unit load).
module wait_fare_meter
   import wait_fare_meter_pkg::*;
#(
   parameter int CNT_W          = 8,
   parameter int UNIT_W         = 5,
   parameter int DAY_UNIT_MIN   = DEF_DAY_UNIT_MIN,
   parameter int NIGHT_UNIT_MIN = DEF_NIGHT_UNIT_MIN,
   parameter int GRACE_MIN      = DEF_GRACE_MIN
) (
   input  logic                clk,
   input  logic                rst,
   wait_fare_meter_if.slave    bus,
   output meter_state_e        state
);

   localparam int                UNIT_MAX   = (1 << UNIT_W) - 1;
   localparam logic [UNIT_W-1:0] DAY_LEN    = UNIT_W'(DAY_UNIT_MIN);
   localparam logic [UNIT_W-1:0] NIGHT_LEN  = UNIT_W'(NIGHT_UNIT_MIN);
   localparam logic [UNIT_W-1:0] GRACE_INIT = UNIT_W'(GRACE_MIN);
   localparam logic              GRACE_ON   = (GRACE_MIN > 0) ? 1'b1 : 1'b0;

   if (DAY_UNIT_MIN < 1 || DAY_UNIT_MIN > UNIT_MAX) begin : g_bad_day
      $error("DAY_UNIT_MIN out of range 1..2^UNIT_W-1");
   end
   if (NIGHT_UNIT_MIN < 1 || NIGHT_UNIT_MIN > UNIT_MAX) begin : g_bad_night
      $error("NIGHT_UNIT_MIN out of range 1..2^UNIT_W-1");
   end
   if (GRACE_MIN < 0 || GRACE_MIN > UNIT_MAX) begin : g_bad_grace
      $error("GRACE_MIN must be below 2^UNIT_W");
   end

   meter_state_e      state_q;
   logic              fare_q;
   logic              in_grace_q;
   logic [UNIT_W-1:0] grace_q;
   logic [UNIT_W-1:0] unit_q;
   logic [UNIT_W-1:0] reload_len;
   logic              qtick;
   logic              min_inc;
   logic              unit_done;
   logic              wmin_sat;
   logic              units_sat;

   // trip_start wins over a coincident tick, so the tick is masked here.
   assign qtick      = bus.tick_min & bus.trip_active & bus.waiting & ~bus.trip_start;
   assign reload_len = bus.night_mode ? NIGHT_LEN : DAY_LEN;
   assign min_inc    = qtick & (state_q != ST_IDLE);
   // A unit completing right after a pulse is held at 1 until the next
   // qualified minute, so fare_pulse can never be high two cycles running.
   assign unit_done  = qtick & (state_q == ST_BILL) & (unit_q == UNIT_W'(1)) & ~fare_q;

   // Meter FSM with grace/unit down-counters and the registered fare pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         fare_q     <= 1'b0;
         in_grace_q <= GRACE_ON;
         grace_q    <= GRACE_INIT;
         unit_q     <= DAY_LEN;
      end else begin
         fare_q <= 1'b0;
         if (bus.trip_start) begin
            state_q    <= ST_IDLE;
            in_grace_q <= GRACE_ON;
            grace_q    <= GRACE_INIT;
            unit_q     <= DAY_LEN;
         end else begin
            unique case (state_q)
               ST_IDLE: begin
                  // Resuming a trip skips grace if it was already used up.
                  if (bus.trip_active) begin
                     state_q <= (grace_q != '0) ? ST_GRACE : ST_BILL;
                  end
               end
               ST_GRACE: begin
                  if (!bus.trip_active) begin
                     state_q <= ST_IDLE;
                  end else if (qtick) begin
                     grace_q <= grace_q - UNIT_W'(1);
                     if (grace_q == UNIT_W'(1)) begin
                        in_grace_q <= 1'b0;
                        state_q    <= ST_BILL;
                        unit_q     <= reload_len;
                     end
                  end
               end
               ST_BILL: begin
                  if (!bus.trip_active) begin
                     state_q <= ST_IDLE;
                  end else if (qtick) begin
                     if (unit_q != UNIT_W'(1)) begin
                        unit_q <= unit_q - UNIT_W'(1);
                     end else if (unit_done) begin
                        fare_q <= 1'b1;
                        unit_q <= reload_len;
                     end
                  end
               end
               default: begin
                  state_q <= ST_IDLE;
               end
            endcase
         end
      end
   end

   wait_fare_meter_sat_counter #(.W(CNT_W)) u_wait_min (
      .clk   (clk),
      .rst   (rst),
      .clear (bus.trip_start),
      .inc   (min_inc),
      .count (bus.wait_min),
      .sat   (wmin_sat)
   );

   wait_fare_meter_sat_counter #(.W(CNT_W)) u_wait_units (
      .clk   (clk),
      .rst   (rst),
      .clear (bus.trip_start),
      .inc   (unit_done),
      .count (bus.wait_units),
      .sat   (units_sat)
   );

   // Counters only move up within a trip, so an at-max flag is already sticky.
   assign bus.sat        = wmin_sat | units_sat;
   assign bus.fare_pulse = fare_q;
   assign bus.in_grace   = in_grace_q;
   assign state          = state_q;

endmodule

// File: tb/tb_wait_fare_meter.sv
// Bench for wait_fare_meter: two instances (default parameters and a narrow
// CNT_W=3 / no-grace / one-minute-unit variant) share one stimulus stream.
module tb_wait_fare_meter;
   import wait_fare_meter_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk;
   logic rst;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic tick_r, start_r, active_r, waiting_r, night_r;
   meter_state_e st0, st1;

   wait_fare_meter_if #(.CNT_W(8)) bus0();
   wait_fare_meter_if #(.CNT_W(3)) bus1();

   assign bus0.tick_min    = tick_r;
   assign bus0.trip_start  = start_r;
   assign bus0.trip_active = active_r;
   assign bus0.waiting     = waiting_r;
   assign bus0.night_mode  = night_r;
   assign bus1.tick_min    = tick_r;
   assign bus1.trip_start  = start_r;
   assign bus1.trip_active = active_r;
   assign bus1.waiting     = waiting_r;
   assign bus1.night_mode  = night_r;

   wait_fare_meter #(.CNT_W(8), .UNIT_W(5), .DAY_UNIT_MIN(10), .NIGHT_UNIT_MIN(5),
                     .GRACE_MIN(3)) u_dut0 (
      .clk   (clk),
      .rst   (rst),
      .bus   (bus0),
      .state (st0)
   );

   wait_fare_meter #(.CNT_W(3), .UNIT_W(5), .DAY_UNIT_MIN(1), .NIGHT_UNIT_MIN(2),
                     .GRACE_MIN(0)) u_dut1 (
      .clk   (clk),
      .rst   (rst),
      .bus   (bus1),
      .state (st1)
   );

   // ---------------- reference model ----------------
   int cfg_grace[2] = '{3, 0};
   int cfg_day[2]   = '{10, 1};
   int cfg_night[2] = '{5, 2};
   int cfg_max[2]   = '{255, 7};

   int m_min[2];     // qualified minutes this trip (unbounded)
   int m_units[2];   // completed units this trip (unbounded)
   int m_grace[2];   // grace minutes still free
   int m_len[2];     // length of the unit in progress
   int m_into[2];    // minutes already spent in that unit
   bit m_pulse[2];   // fare pulse expected to be visible now
   bit m_run;        // meter is timing a trip this cycle

   int total = 0;
   int bad   = 0;
   int pulses1;
   logic [7:0] exp_q[$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int clip(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_min[k]   = 0;
         m_units[k] = 0;
         m_grace[k] = cfg_grace[k];
         m_len[k]   = cfg_day[k];
         m_into[k]  = 0;
         m_pulse[k] = 1'b0;
      end
      m_run = 1'b0;
   endtask

   // One clock edge of trip rules applied to the inputs present at that edge.
   task automatic model_step();
      for (int k = 0; k < 2; k++) begin
         bit np;
         np = 1'b0;
         if (start_r) begin
            m_min[k]   = 0;
            m_units[k] = 0;
            m_grace[k] = cfg_grace[k];
            m_len[k]   = cfg_day[k];
            m_into[k]  = 0;
         end else if (m_run && tick_r && active_r && waiting_r) begin
            m_min[k]++;
            if (m_grace[k] > 0) begin
               m_grace[k]--;
               if (m_grace[k] == 0) begin
                  m_len[k]  = night_r ? cfg_night[k] : cfg_day[k];
                  m_into[k] = 0;
               end
            end else begin
               m_into[k]++;
               if (m_into[k] >= m_len[k] && !m_pulse[k]) begin
                  m_units[k]++;
                  m_into[k] = 0;
                  m_len[k]  = night_r ? cfg_night[k] : cfg_day[k];
                  np = 1'b1;
                  if (k == 0) exp_q.push_back(8'(clip(m_units[0], 255)));
               end
            end
         end
         m_pulse[k] = np;
      end
      m_run = active_r && !start_r;
   endtask

   function automatic logic [1:0] exp_state(input int k);
      if (!m_run) return ST_IDLE;
      return (m_grace[k] > 0) ? ST_GRACE : ST_BILL;
   endfunction

   // ---------------- scoreboard ----------------
   task automatic check_all();
      logic [7:0] e;
      check_eq("d0_pulse", bus0.fare_pulse, m_pulse[0]);
      check_eq("d0_wait_min", bus0.wait_min, clip(m_min[0], 255));
      check_eq("d0_wait_units", bus0.wait_units, clip(m_units[0], 255));
      check_eq("d0_in_grace", bus0.in_grace, m_grace[0] > 0);
      check_eq("d0_sat", bus0.sat, (m_min[0] >= 255) || (m_units[0] >= 255));
      check_eq("d0_state", st0, exp_state(0));
      check_eq("d1_pulse", bus1.fare_pulse, m_pulse[1]);
      check_eq("d1_wait_min", bus1.wait_min, clip(m_min[1], 7));
      check_eq("d1_wait_units", bus1.wait_units, clip(m_units[1], 7));
      check_eq("d1_in_grace", bus1.in_grace, m_grace[1] > 0);
      check_eq("d1_sat", bus1.sat, (m_min[1] >= 7) || (m_units[1] >= 7));
      check_eq("d1_state", st1, exp_state(1));
      if (bus0.fare_pulse || exp_q.size() != 0) begin
         check_eq("d0_sb_pulse", bus0.fare_pulse, exp_q.size() != 0);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_eq("d0_sb_units", bus0.wait_units, e);
         end
      end
      if (bus1.fare_pulse) pulses1++;
   endtask

   // ---------------- driver tasks ----------------
   task automatic run_cycle();
      @(posedge clk);
      model_step();
      #1;
      check_all();
   endtask

   task automatic tick_once();
      tick_r = 1'b1;
      run_cycle();
      tick_r = 1'b0;
      run_cycle();
   endtask

   task automatic new_trip();
      start_r   = 1'b1;
      active_r  = 1'b1;
      waiting_r = 1'b1;
      run_cycle();
      start_r = 1'b0;
      run_cycle();
      pulses1 = 0;
   endtask

   task automatic check_reset_values(input string tag);
      check_eq({tag, "_d0_pulse"}, bus0.fare_pulse, 0);
      check_eq({tag, "_d0_min"}, bus0.wait_min, 0);
      check_eq({tag, "_d0_units"}, bus0.wait_units, 0);
      check_eq({tag, "_d0_grace"}, bus0.in_grace, 1);
      check_eq({tag, "_d0_sat"}, bus0.sat, 0);
      check_eq({tag, "_d0_state"}, st0, ST_IDLE);
      check_eq({tag, "_d1_grace"}, bus1.in_grace, 0);
      check_eq({tag, "_d1_units"}, bus1.wait_units, 0);
   endtask

   // Raise rst between edges and look before the next edge arrives.
   task automatic async_reset(input string tag);
      #2 rst = 1'b1;
      #1 check_reset_values(tag);
      model_reset();
      exp_q.delete();
      @(posedge clk);
      #1 rst = 1'b0;
      tick_r  = 1'b0;
      start_r = 1'b0;
   endtask

   // ---------------- test sequence ----------------
   initial begin
      rst = 1'b1;
      tick_r = 1'b0; start_r = 1'b0; active_r = 1'b0; waiting_r = 1'b0; night_r = 1'b0;
      pulses1 = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      check_reset_values("reset");
      check_all();

      // Day billing: grace 3, then 10-minute units.
      night_r = 1'b0;
      new_trip();
      for (int i = 1; i <= 23; i++) begin
         tick_r = 1'b1;
         run_cycle();
         if (i == 2) check_eq("day_in_grace_t2", bus0.in_grace, 1);
         if (i == 3) check_eq("day_in_grace_t3", bus0.in_grace, 0);
         if (i == 13 || i == 23) check_eq("day_pulse", bus0.fare_pulse, 1);
         tick_r = 1'b0;
         run_cycle();
      end
      check_eq("day_units", bus0.wait_units, 2);
      check_eq("day_min", bus0.wait_min, 23);

      // Mode switch mid-unit takes effect only at the next reload.
      night_r = 1'b0;
      new_trip();
      for (int i = 1; i <= 18; i++) begin
         tick_r = 1'b1;
         run_cycle();
         if (i == 12) check_eq("mode_no_pulse_t12", bus0.fare_pulse, 0);
         if (i == 13 || i == 18) check_eq("mode_pulse", bus0.fare_pulse, 1);
         tick_r = 1'b0;
         run_cycle();
         if (i == 5) night_r = 1'b1;
      end
      check_eq("mode_units", bus0.wait_units, 2);
      night_r = 1'b0;

      // Pause: partial unit retained while waiting is low.
      new_trip();
      repeat (8) tick_once();
      waiting_r = 1'b0;
      repeat (10) tick_once();
      check_eq("pause_min_held", bus0.wait_min, 8);
      check_eq("pause_units_held", bus0.wait_units, 0);
      waiting_r = 1'b1;
      repeat (4) tick_once();
      tick_r = 1'b1;
      run_cycle();
      check_eq("pause_pulse", bus0.fare_pulse, 1);
      tick_r = 1'b0;
      run_cycle();
      check_eq("pause_min", bus0.wait_min, 13);
      check_eq("pause_units", bus0.wait_units, 1);

      // trip_start coincident with a tick mid-unit.
      new_trip();
      repeat (6) tick_once();
      tick_r  = 1'b1;
      start_r = 1'b1;
      run_cycle();
      tick_r  = 1'b0;
      start_r = 1'b0;
      check_eq("start_min", bus0.wait_min, 0);
      check_eq("start_units", bus0.wait_units, 0);
      check_eq("start_in_grace", bus0.in_grace, 1);
      check_eq("start_state", st0, ST_IDLE);
      check_eq("start_pulse", bus0.fare_pulse, 0);
      run_cycle();

      // Saturation on the narrow instance: one-minute units, no grace.
      new_trip();
      repeat (9) tick_once();
      check_eq("sat_units", bus1.wait_units, 7);
      check_eq("sat_min", bus1.wait_min, 7);
      check_eq("sat_flag", bus1.sat, 1);
      check_eq("sat_pulses", pulses1, 9);

      // Asynchronous reset in the middle of the sixth minute.
      new_trip();
      repeat (5) tick_once();
      tick_r = 1'b1;
      async_reset("arst");
      run_cycle();
      check_eq("arst_no_pulse", bus0.fare_pulse, 0);
      check_eq("arst_min", bus0.wait_min, 0);

      // Randomised trips checked cycle by cycle against the model.
      for (int c = 0; c < 3000; c++) begin
         start_r = ($urandom_range(0, 63) == 0);
         if ($urandom_range(0, 31) == 0) active_r  = ~active_r;
         if ($urandom_range(0, 7)  == 0) waiting_r = ~waiting_r;
         if ($urandom_range(0, 15) == 0) night_r   = ~night_r;
         tick_r = ($urandom_range(0, 2) == 0);
         run_cycle();
         if ($urandom_range(0, 399) == 0) async_reset("rnd_arst");
      end
      tick_r  = 1'b0;
      start_r = 1'b0;
      run_cycle();
      run_cycle();
      check_eq("sb_drained", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
